// File: rtl/obi_protocol_tracker.sv
// ---------------------------------------------------------------------------
// obi_protocol_tracker
//   Tracks outstanding OBI transactions on NUM_CH independent channels.
//   It tells a random responder when gnt/rvalid may legally be driven, and
//   it records the first protocol violation seen on each channel.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous clear of the sticky violation state (all channels)
//   req_i        OBI req, one bit per channel
//   gnt_i        OBI gnt, one bit per channel
//   rvalid_i     OBI rvalid, one bit per channel
//   we_i         OBI write enable, one bit per channel
//   be_i         byte enables, channel c at [4c+3:4c]
//   addr_i       address, channel c at [ADDR_W*c +: ADDR_W]
//   pend_o       outstanding (granted, not yet answered) count per channel
//   gnt_ok_o     combinational: a gnt is legal on the channel this cycle
//   rvalid_ok_o  combinational: an rvalid is legal on the channel this cycle
//   viol_o       sticky: a violation has occurred on the channel
//   viol_code_o  code of the first violation on the channel (0 = none)
//
// Violation codes
//   1 gnt without req            4 gnt timeout
//   2 rvalid with nothing pending 5 rvalid timeout
//   3 req retracted/changed      6 overflow (accept while full, no rvalid)
// ---------------------------------------------------------------------------
module obi_protocol_tracker #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned GNT_TMO  = 8,
    parameter int unsigned RVLD_TMO = 8,
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1),
    localparam int unsigned TMO_MAX = (GNT_TMO > RVLD_TMO) ? GNT_TMO : RVLD_TMO,
    localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH-1:0]          gnt_i,
    input  logic [NUM_CH-1:0]          rvalid_i,
    input  logic [NUM_CH-1:0]          we_i,
    input  logic [NUM_CH*4-1:0]        be_i,
    input  logic [NUM_CH*ADDR_W-1:0]   addr_i,
    output logic [NUM_CH*CNT_W-1:0]    pend_o,
    output logic [NUM_CH-1:0]          gnt_ok_o,
    output logic [NUM_CH-1:0]          rvalid_ok_o,
    output logic [NUM_CH-1:0]          viol_o,
    output logic [NUM_CH*3-1:0]        viol_code_o
);

    localparam logic [CNT_W-1:0] PEND_ZERO_C = CNT_W'(0);
    localparam logic [CNT_W-1:0] PEND_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PEND_MAX_C  = CNT_W'(MAX_OUT);
    localparam logic [TMO_W-1:0] TMO_ZERO_C  = TMO_W'(0);
    localparam logic [TMO_W-1:0] TMO_ONE_C   = TMO_W'(1);
    localparam logic [TMO_W-1:0] GNT_SAT_C   = TMO_W'(GNT_TMO);
    localparam logic [TMO_W-1:0] GNT_LIM_C   = TMO_W'(GNT_TMO - 1);
    localparam logic [TMO_W-1:0] RVLD_SAT_C  = TMO_W'(RVLD_TMO);
    localparam logic [TMO_W-1:0] RVLD_LIM_C  = TMO_W'(RVLD_TMO - 1);

    // Lowest set bit wins: bit k of the vector stands for code k+1.
    function automatic logic [2:0] first_code(input logic [5:0] vec);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (vec[i]) begin
                code = 3'(i + 1);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              req_s;
        logic              gnt_s;
        logic              rvalid_s;
        logic              we_s;
        logic [3:0]        be_s;
        logic [ADDR_W-1:0] addr_s;

        logic [CNT_W-1:0]  pend_r;
        logic [CNT_W-1:0]  pend_nxt_s;
        logic [TMO_W-1:0]  gwait_r;
        logic [TMO_W-1:0]  gwait_nxt_s;
        logic [TMO_W-1:0]  rwait_r;
        logic [TMO_W-1:0]  rwait_nxt_s;
        logic              waiting_r;
        logic [ADDR_W-1:0] addr_lat_r;
        logic              we_lat_r;
        logic [3:0]        be_lat_r;
        logic              viol_r;
        logic [2:0]        code_r;

        logic              acc_s;
        logic              ret_s;
        logic              pend_nz_s;
        logic              pend_full_s;
        logic              gnt_wait_s;
        logic              rvld_wait_s;
        logic              fields_chg_s;
        logic [5:0]        viol_vec_s;

        assign req_s    = req_i[c];
        assign gnt_s    = gnt_i[c];
        assign rvalid_s = rvalid_i[c];
        assign we_s     = we_i[c];
        assign be_s     = be_i[4*c +: 4];
        assign addr_s   = addr_i[ADDR_W*c +: ADDR_W];

        // A response only retires something when there is something pending.
        assign acc_s        = req_s & gnt_s;
        assign pend_nz_s    = (pend_r != PEND_ZERO_C);
        assign pend_full_s  = (pend_r == PEND_MAX_C);
        assign ret_s        = rvalid_s & pend_nz_s;
        assign gnt_wait_s   = req_s & ~gnt_s;
        assign rvld_wait_s  = pend_nz_s & ~rvalid_s;
        assign fields_chg_s = (addr_s != addr_lat_r) | (we_s != we_lat_r) |
                              (be_s != be_lat_r);

        // Violation detection; bit k flags code k+1.
        always_comb begin
            viol_vec_s    = 6'b000000;
            viol_vec_s[0] = gnt_s & ~req_s;
            viol_vec_s[1] = rvalid_s & ~pend_nz_s;
            viol_vec_s[2] = waiting_r & (~req_s | fields_chg_s);
            viol_vec_s[3] = gnt_wait_s & (gwait_r >= GNT_LIM_C);
            viol_vec_s[4] = rvld_wait_s & (rwait_r >= RVLD_LIM_C);
            viol_vec_s[5] = acc_s & pend_full_s & ~rvalid_s;
        end

        // Outstanding count: saturating up/down, accept+retire holds.
        always_comb begin
            pend_nxt_s = pend_r;
            if (acc_s & ~ret_s) begin
                if (pend_full_s) begin
                    pend_nxt_s = pend_r;
                end else begin
                    pend_nxt_s = pend_r + PEND_ONE_C;
                end
            end else if (ret_s & ~acc_s) begin
                pend_nxt_s = pend_r - PEND_ONE_C;
            end else begin
                pend_nxt_s = pend_r;
            end
        end

        // Wait counters saturate at their timeout so they never wrap.
        always_comb begin
            gwait_nxt_s = TMO_ZERO_C;
            rwait_nxt_s = TMO_ZERO_C;
            if (gnt_wait_s) begin
                if (gwait_r < GNT_SAT_C) begin
                    gwait_nxt_s = gwait_r + TMO_ONE_C;
                end else begin
                    gwait_nxt_s = gwait_r;
                end
            end else begin
                gwait_nxt_s = TMO_ZERO_C;
            end
            if (rvld_wait_s) begin
                if (rwait_r < RVLD_SAT_C) begin
                    rwait_nxt_s = rwait_r + TMO_ONE_C;
                end else begin
                    rwait_nxt_s = rwait_r;
                end
            end else begin
                rwait_nxt_s = TMO_ZERO_C;
            end
        end

        // Outstanding count and wait counters (not affected by clear_i).
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pend_r  <= PEND_ZERO_C;
                gwait_r <= TMO_ZERO_C;
                rwait_r <= TMO_ZERO_C;
            end else begin
                pend_r  <= pend_nxt_s;
                gwait_r <= gwait_nxt_s;
                rwait_r <= rwait_nxt_s;
            end
        end

        // Request stability: remember an ungranted request so next cycle can compare.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                waiting_r  <= 1'b0;
                addr_lat_r <= {ADDR_W{1'b0}};
                we_lat_r   <= 1'b0;
                be_lat_r   <= 4'b0000;
            end else begin
                waiting_r <= gnt_wait_s;
                if (gnt_wait_s) begin
                    addr_lat_r <= addr_s;
                    we_lat_r   <= we_s;
                    be_lat_r   <= be_s;
                end
            end
        end

        // Sticky first-violation capture; clear wins over a same-cycle violation.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                viol_r <= 1'b0;
                code_r <= 3'd0;
            end else if (clear_i) begin
                viol_r <= 1'b0;
                code_r <= 3'd0;
            end else if (!viol_r && (viol_vec_s != 6'b000000)) begin
                viol_r <= 1'b1;
                code_r <= first_code(viol_vec_s);
            end
        end

        // A same-cycle rvalid frees a slot, so a full channel may still grant.
        assign gnt_ok_o[c]             = req_s & (~pend_full_s | rvalid_s);
        assign rvalid_ok_o[c]          = pend_nz_s;
        assign pend_o[c*CNT_W +: CNT_W] = pend_r;
        assign viol_o[c]               = viol_r;
        assign viol_code_o[3*c +: 3]   = code_r;
    end

endmodule

// File: tb/tb_obi_protocol_tracker.sv
module tb_obi_protocol_tracker;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int MO  = 2;
    localparam int GT  = 8;
    localparam int RT  = 8;
    localparam int CW  = $clog2(MO + 1);

    logic                clk;
    logic                rst_n;
    logic                clear;
    logic [NCH-1:0]      req, gnt, rvalid, we;
    logic [NCH*4-1:0]    be;
    logic [NCH*AW-1:0]   addr;
    logic [NCH*CW-1:0]   pend_o;
    logic [NCH-1:0]      gnt_ok_o, rvalid_ok_o, viol_o;
    logic [NCH*3-1:0]    viol_code_o;

    obi_protocol_tracker #(
        .NUM_CH(NCH), .ADDR_W(AW), .MAX_OUT(MO), .GNT_TMO(GT), .RVLD_TMO(RT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .req_i(req), .gnt_i(gnt), .rvalid_i(rvalid), .we_i(we), .be_i(be),
        .addr_i(addr), .pend_o(pend_o), .gnt_ok_o(gnt_ok_o),
        .rvalid_ok_o(rvalid_ok_o), .viol_o(viol_o), .viol_code_o(viol_code_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int c, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s ch%0d got=%0d expected=%0d at %0t", name, c, act, exp, $time);
        end
    endtask

    function automatic int d_pend(input int c);
        return int'(pend_o[c*CW +: CW]);
    endfunction

    function automatic int d_code(input int c);
        return int'(viol_code_o[3*c +: 3]);
    endfunction

    // ---------------- behavioural model ----------------
    int          m_pend [NCH];
    int          m_gw   [NCH];
    int          m_rw   [NCH];
    bit          m_wait [NCH];
    logic [AW-1:0] m_addr [NCH];
    logic        m_we   [NCH];
    logic [3:0]  m_be   [NCH];
    bit          m_viol [NCH];
    int          m_code [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pend[c] = 0; m_gw[c] = 0; m_rw[c] = 0; m_wait[c] = 0;
            m_addr[c] = '0; m_we[c] = 1'b0; m_be[c] = 4'h0;
            m_viol[c] = 0; m_code[c] = 0;
        end
    endtask

    task automatic model_step();
        bit r, g, v, w;
        logic [AW-1:0] a;
        logic [3:0] b;
        bit [6:1] hit;
        int p, first, ngw, nrw;
        for (int c = 0; c < NCH; c++) begin
            r = req[c]; g = gnt[c]; v = rvalid[c]; w = we[c];
            a = addr[c*AW +: AW]; b = be[c*4 +: 4];
            ngw = (r && !g) ? m_gw[c] + 1 : 0;
            nrw = (m_pend[c] > 0 && !v) ? m_rw[c] + 1 : 0;
            hit[1] = g && !r;
            hit[2] = v && (m_pend[c] == 0);
            hit[3] = m_wait[c] && (!r || a != m_addr[c] || w != m_we[c] || b != m_be[c]);
            hit[4] = ngw >= GT;
            hit[5] = nrw >= RT;
            hit[6] = r && g && (m_pend[c] == MO) && !v;
            first = 0;
            for (int k = 6; k >= 1; k--) if (hit[k]) first = k;
            if (clear) begin
                m_viol[c] = 0; m_code[c] = 0;
            end else if (!m_viol[c] && first != 0) begin
                m_viol[c] = 1; m_code[c] = first;
            end
            p = m_pend[c] + int'(r && g) - int'(v && m_pend[c] > 0);
            if (p > MO) p = MO;
            if (p < 0) p = 0;
            m_pend[c] = p;
            m_gw[c] = ngw;
            m_rw[c] = nrw;
            m_wait[c] = r && !g;
            if (r && !g) begin
                m_addr[c] = a; m_we[c] = w; m_be[c] = b;
            end
        end
    endtask

    // Model advances on every active edge outside reset.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
        end
    end

    // Asynchronous reset drops the model immediately as well.
    initial begin
        forever begin
            @(negedge rst_n);
            model_reset();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                chk("pend", c, d_pend(c), m_pend[c]);
                chk("gnt_ok", c, gnt_ok_o[c], int'(req[c] && (m_pend[c] < MO || rvalid[c])));
                chk("rvalid_ok", c, rvalid_ok_o[c], int'(m_pend[c] > 0));
                chk("viol", c, viol_o[c], m_viol[c]);
                chk("code", c, d_code(c), m_code[c]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input bit r, input bit g, input bit v, input logic [AW-1:0] a);
        req[c] = r; gnt[c] = g; rvalid[c] = v; we[c] = 1'b0;
        be[c*4 +: 4] = 4'hf;
        addr[c*AW +: AW] = a;
    endtask

    task automatic idle_all();
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 1'b0, 1'b0, 32'h0);
        clear = 1'b0;
    endtask

    task automatic clear_pulse();
        tick(); idle_all(); clear = 1'b1;
        tick(); clear = 1'b0;
    endtask

    task automatic rand_cycle();
        bit r, g, v, ok;
        for (int c = 0; c < NCH; c++) begin
            r = ($urandom_range(0, 99) < 60);
            if (m_wait[c] && $urandom_range(0, 99) < 95) r = 1'b1;
            v = (m_pend[c] > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 2);
            ok = r && (m_pend[c] < MO || v);
            g = ok ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 3);
            req[c] = r; gnt[c] = g; rvalid[c] = v;
            if (m_wait[c] && $urandom_range(0, 99) < 95) begin
                addr[c*AW +: AW] = m_addr[c];
                we[c] = m_we[c];
                be[c*4 +: 4] = m_be[c];
            end else begin
                addr[c*AW +: AW] = $urandom;
                we[c] = 1'($urandom_range(0, 1));
                be[c*4 +: 4] = 4'($urandom_range(0, 15));
            end
        end
        clear = ($urandom_range(0, 99) < 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pend", 0, d_pend(0), 0);
        chk("rst_viol", 0, viol_o, 0);
        chk("rst_code", 0, viol_code_o, 0);
        rst_n = 1'b1;

        // 1: two accepts, two responses, pend 1,2,2,1,0
        tick(); set_ch(0, 1, 1, 0, 32'h10); #1;
        chk("t1_pend_c0", 0, d_pend(0), 0);
        chk("t1_rvok_c0", 0, rvalid_ok_o[0], 0);
        tick(); set_ch(0, 1, 1, 0, 32'h14); #1;
        chk("t1_pend_c1", 0, d_pend(0), 1);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t1_pend_c2", 0, d_pend(0), 2);
        chk("t1_gntok_c2", 0, gnt_ok_o[0], 0);
        chk("t1_rvok_c2", 0, rvalid_ok_o[0], 1);
        tick(); set_ch(0, 0, 0, 1, 32'h0); #1;
        chk("t1_pend_c3", 0, d_pend(0), 2);
        tick(); set_ch(0, 0, 0, 1, 32'h0); #1;
        chk("t1_pend_c4", 0, d_pend(0), 1);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t1_pend_c5", 0, d_pend(0), 0);
        chk("t1_viol", 0, viol_o, 0);

        // 2: full channel, accept + response in the same cycle
        tick(); set_ch(0, 1, 1, 0, 32'h20);
        tick(); set_ch(0, 1, 1, 0, 32'h24);
        tick(); set_ch(0, 1, 0, 0, 32'h200); #1;
        chk("t2_pend_full", 0, d_pend(0), 2);
        chk("t2_gntok_full", 0, gnt_ok_o[0], 0);
        tick(); set_ch(0, 1, 1, 1, 32'h200); #1;
        chk("t2_gntok_rv", 0, gnt_ok_o[0], 1);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t2_pend_hold", 0, d_pend(0), 2);
        tick(); set_ch(0, 0, 0, 1, 32'h0);
        tick(); set_ch(0, 0, 0, 1, 32'h0);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t2_pend_drain", 0, d_pend(0), 0);
        chk("t2_viol", 0, viol_o, 0);

        // 3: gnt without req on channel 1 only
        tick(); set_ch(1, 0, 1, 0, 32'h0);
        tick(); set_ch(1, 0, 0, 0, 32'h0); #1;
        chk("t3_viol_vec", 0, viol_o, 2);
        chk("t3_code_ch1", 1, d_code(1), 1);
        chk("t3_code_ch0", 0, d_code(0), 0);
        clear_pulse(); #1;
        chk("t3_cleared", 0, viol_o, 0);

        // 4: address changes while waiting for gnt
        tick(); set_ch(0, 1, 0, 0, 32'h100);
        tick(); set_ch(0, 1, 0, 0, 32'h104); #1;
        chk("t4_not_yet", 0, viol_o[0], 0);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t4_viol", 0, viol_o[0], 1);
        chk("t4_code", 0, d_code(0), 3);
        clear_pulse();

        // 5: gnt timeout, first violation wins, then clear
        for (int i = 0; i < GT; i++) begin
            tick(); set_ch(0, 1, 0, 0, 32'h300); #1;
            if (i == GT - 1) chk("t5_before_tmo", 0, viol_o[0], 0);
        end
        tick(); set_ch(0, 0, 0, 1, 32'h0); #1;
        chk("t5_viol", 0, viol_o[0], 1);
        chk("t5_code", 0, d_code(0), 4);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t5_code_kept", 0, d_code(0), 4);
        clear_pulse(); #1;
        chk("t5_cleared", 0, viol_o, 0);
        chk("t5_code_cleared", 0, viol_code_o, 0);

        // 6: asynchronous reset mid-transaction, late response flagged
        tick(); set_ch(0, 1, 1, 0, 32'h400);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t6_pend_before", 0, d_pend(0), 1);
        #1 rst_n = 1'b0;
        #1 chk("t6_pend_async", 0, d_pend(0), 0);
        tick(); rst_n = 1'b1;
        tick(); set_ch(0, 0, 0, 1, 32'h0);
        tick(); set_ch(0, 0, 0, 0, 32'h0); #1;
        chk("t6_viol", 0, viol_o[0], 1);
        chk("t6_code", 0, d_code(0), 2);
        clear_pulse();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_cycle();
        end
        tick(); idle_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
